// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with operand forwarding muxes and saturating
// bubble/hold event counters.
module id_ex_pipeline_reg #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              bubble,
    input  logic              stall,
    input  logic [1:0]        fwd1_sel,
    input  logic [1:0]        fwd2_sel,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_data1,
    input  logic [XLEN-1:0]   id_data2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [4:0]        id_rd,
    input  logic              id_we,
    input  logic              id_memr,
    input  logic              id_memw,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [XLEN-1:0]   ex_fwd_data,
    input  logic [XLEN-1:0]   mem_fwd_data,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_data1,
    output logic [XLEN-1:0]   ex_data2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rd,
    output logic              ex_we,
    output logic              ex_memr,
    output logic              ex_memw,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  hold_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;

    // Reserved select 11 falls back to the register file value.
    always_comb begin
        op1 = id_data1;
        op2 = id_data2;
        case (fwd1_sel)
            2'b01:   op1 = ex_fwd_data;
            2'b10:   op1 = mem_fwd_data;
            default: op1 = id_data1;
        endcase
        case (fwd2_sel)
            2'b01:   op2 = ex_fwd_data;
            2'b10:   op2 = mem_fwd_data;
            default: op2 = id_data2;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid   <= 1'b0;
            ex_pc      <= '0;
            ex_data1   <= '0;
            ex_data2   <= '0;
            ex_imm     <= '0;
            ex_rd      <= '0;
            ex_we      <= 1'b0;
            ex_memr    <= 1'b0;
            ex_memw    <= 1'b0;
            ex_ctrl    <= '0;
            bubble_cnt <= '0;
            hold_cnt   <= '0;
        end else if (flush || bubble) begin
            // Full NOP so the hazard unit never sees a phantom producer.
            ex_valid <= 1'b0;
            ex_pc    <= '0;
            ex_data1 <= '0;
            ex_data2 <= '0;
            ex_imm   <= '0;
            ex_rd    <= '0;
            ex_we    <= 1'b0;
            ex_memr  <= 1'b0;
            ex_memw  <= 1'b0;
            ex_ctrl  <= '0;
            if (!flush && bubble_cnt != CNT_MAX)
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end else if (stall) begin
            if (hold_cnt != CNT_MAX)
                hold_cnt <= hold_cnt + CNT_W'(1);
        end else begin
            ex_valid <= id_valid;
            ex_pc    <= id_pc;
            ex_data1 <= op1;
            ex_data2 <= op2;
            ex_imm   <= id_imm;
            ex_rd    <= id_rd;
            ex_we    <= id_we;
            ex_memr  <= id_memr;
            ex_memw  <= id_memw;
            ex_ctrl  <= id_ctrl;
        end
    end

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Scoreboard bench for id_ex_pipeline_reg: a reference model pushes expected
// EX contents per edge; they are popped and compared one cycle later.
module tb_id_ex_pipeline_reg;

    logic        clk = 1'b0;
    logic        reset, flush, bubble, stall;
    logic [1:0]  fwd1_sel, fwd2_sel;
    logic        id_valid, id_we, id_memr, id_memw;
    logic [31:0] id_pc, id_data1, id_data2, id_imm, ex_fwd_data, mem_fwd_data;
    logic [4:0]  id_rd;
    logic [11:0] id_ctrl;

    logic        ex_valid, ex_we, ex_memr, ex_memw;
    logic [31:0] ex_pc, ex_data1, ex_data2, ex_imm;
    logic [4:0]  ex_rd;
    logic [11:0] ex_ctrl;
    logic [15:0] bubble_cnt, hold_cnt;

    logic        s_valid, s_we, s_memr, s_memw;
    logic [31:0] s_pc, s_data1, s_data2, s_imm;
    logic [4:0]  s_rd;
    logic [11:0] s_ctrl;
    logic [3:0]  s_bubble_cnt, s_hold_cnt;

    always #5 clk = ~clk;

    id_ex_pipeline_reg dut (
        .clk(clk), .reset(reset), .flush(flush), .bubble(bubble), .stall(stall),
        .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel), .id_valid(id_valid),
        .id_pc(id_pc), .id_data1(id_data1), .id_data2(id_data2), .id_imm(id_imm),
        .id_rd(id_rd), .id_we(id_we), .id_memr(id_memr), .id_memw(id_memw),
        .id_ctrl(id_ctrl), .ex_fwd_data(ex_fwd_data), .mem_fwd_data(mem_fwd_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_data1(ex_data1), .ex_data2(ex_data2),
        .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_we(ex_we), .ex_memr(ex_memr),
        .ex_memw(ex_memw), .ex_ctrl(ex_ctrl), .bubble_cnt(bubble_cnt),
        .hold_cnt(hold_cnt)
    );

    // Narrow-counter copy sharing the same stimulus, for saturation.
    id_ex_pipeline_reg #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .flush(flush), .bubble(bubble), .stall(stall),
        .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel), .id_valid(id_valid),
        .id_pc(id_pc), .id_data1(id_data1), .id_data2(id_data2), .id_imm(id_imm),
        .id_rd(id_rd), .id_we(id_we), .id_memr(id_memr), .id_memw(id_memw),
        .id_ctrl(id_ctrl), .ex_fwd_data(ex_fwd_data), .mem_fwd_data(mem_fwd_data),
        .ex_valid(s_valid), .ex_pc(s_pc), .ex_data1(s_data1), .ex_data2(s_data2),
        .ex_imm(s_imm), .ex_rd(s_rd), .ex_we(s_we), .ex_memr(s_memr),
        .ex_memw(s_memw), .ex_ctrl(s_ctrl), .bubble_cnt(s_bubble_cnt),
        .hold_cnt(s_hold_cnt)
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rd;
        logic        we, memr, memw;
        logic [11:0] ctrl;
        logic [15:0] bc, hc;
        logic [3:0]  bcs, hcs;
    } exp_t;

    exp_t m;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] fwd_mux(input logic [1:0] sel, input logic [31:0] id_val);
        if (sel == 2'b01) return ex_fwd_data;
        if (sel == 2'b10) return mem_fwd_data;
        return id_val;
    endfunction

    task automatic model_nop();
        m.valid = 0; m.pc = 0; m.d1 = 0; m.d2 = 0; m.imm = 0;
        m.rd = 0; m.we = 0; m.memr = 0; m.memw = 0; m.ctrl = 0;
    endtask

    task automatic model_edge();
        if (reset) begin
            model_nop();
            m.bc = 0; m.hc = 0; m.bcs = 0; m.hcs = 0;
        end else if (flush) begin
            model_nop();
        end else if (bubble) begin
            model_nop();
            if (m.bc  != 16'hFFFF) m.bc  = m.bc + 16'd1;
            if (m.bcs != 4'hF)     m.bcs = m.bcs + 4'd1;
        end else if (stall) begin
            if (m.hc  != 16'hFFFF) m.hc  = m.hc + 16'd1;
            if (m.hcs != 4'hF)     m.hcs = m.hcs + 4'd1;
        end else begin
            m.valid = id_valid; m.pc = id_pc; m.imm = id_imm;
            m.d1 = fwd_mux(fwd1_sel, id_data1);
            m.d2 = fwd_mux(fwd2_sel, id_data2);
            m.rd = id_rd; m.we = id_we; m.memr = id_memr; m.memw = id_memw;
            m.ctrl = id_ctrl;
        end
    endtask

    task automatic step(input string ph);
        exp_t e;
        model_edge();
        sb.push_back(m);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq({ph, ".valid"}, 64'(ex_valid), 64'(e.valid));
        check_eq({ph, ".pc"},    64'(ex_pc),    64'(e.pc));
        check_eq({ph, ".data1"}, 64'(ex_data1), 64'(e.d1));
        check_eq({ph, ".data2"}, 64'(ex_data2), 64'(e.d2));
        check_eq({ph, ".imm"},   64'(ex_imm),   64'(e.imm));
        check_eq({ph, ".rd"},    64'(ex_rd),    64'(e.rd));
        check_eq({ph, ".we"},    64'(ex_we),    64'(e.we));
        check_eq({ph, ".memr"},  64'(ex_memr),  64'(e.memr));
        check_eq({ph, ".memw"},  64'(ex_memw),  64'(e.memw));
        check_eq({ph, ".ctrl"},  64'(ex_ctrl),  64'(e.ctrl));
        check_eq({ph, ".bubble_cnt"}, 64'(bubble_cnt), 64'(e.bc));
        check_eq({ph, ".hold_cnt"},   64'(hold_cnt),   64'(e.hc));
        check_eq({ph, ".sat_bubble_cnt"}, 64'(s_bubble_cnt), 64'(e.bcs));
        check_eq({ph, ".sat_hold_cnt"},   64'(s_hold_cnt),   64'(e.hcs));
        check_eq({ph, ".sat_rd"}, 64'(s_rd), 64'(e.rd));
    endtask

    task automatic rand_id();
        id_valid = 1'($urandom); id_pc = $urandom; id_data1 = $urandom;
        id_data2 = $urandom; id_imm = $urandom; id_rd = 5'($urandom);
        id_we = 1'($urandom); id_memr = 1'($urandom); id_memw = 1'($urandom);
        id_ctrl = 12'($urandom); ex_fwd_data = $urandom; mem_fwd_data = $urandom;
        fwd1_sel = 2'($urandom); fwd2_sel = 2'($urandom);
    endtask

    task automatic ctl(input logic r, input logic f, input logic b, input logic s);
        reset = r; flush = f; bubble = b; stall = s;
    endtask

    initial begin
        m = '{default: '0};
        rand_id();
        ctl(1, 1'($urandom), 1'($urandom), 1'($urandom));
        step("reset0");
        rand_id();
        step("reset1");

        // Forwarding selects
        ctl(0, 0, 0, 0);
        rand_id();
        id_data1 = 32'h11; id_data2 = 32'h44;
        ex_fwd_data = 32'h22; mem_fwd_data = 32'h33;
        fwd1_sel = 2'b01; fwd2_sel = 2'b10;
        step("fwd_ex_mem");
        fwd1_sel = 2'b11; fwd2_sel = 2'b11;
        step("fwd_rsvd");
        fwd1_sel = 2'b10; fwd2_sel = 2'b01;
        step("fwd_swap");
        fwd1_sel = 2'b00; fwd2_sel = 2'b00;
        step("fwd_id");

        // Load-use: producer in EX, then bubble+stall together
        id_valid = 1; id_we = 1; id_memr = 1; id_rd = 5'd7;
        step("pre_load_use");
        ctl(0, 0, 1, 1);
        id_rd = 5'd5; id_we = 1;
        step("load_use");

        // Hold: capture pc 0x100 then stall 3 cycles with changing inputs
        ctl(0, 0, 0, 0);
        rand_id();
        id_pc = 32'h100;
        step("capture_100");
        ctl(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            rand_id();
            step("hold");
        end
        check_eq("hold.pc_100", 64'(ex_pc), 64'h100);
        check_eq("hold.cnt_3", 64'(hold_cnt), 64'd3);

        // Flush beats bubble; flush with stall also loads NOP
        ctl(0, 0, 0, 0);
        rand_id(); id_valid = 1; id_we = 1;
        step("pre_flush");
        ctl(0, 1, 1, 0);
        step("flush_bubble");
        ctl(0, 0, 0, 0);
        rand_id();
        step("pre_flush_stall");
        ctl(0, 1, 0, 1);
        step("flush_stall");

        // Reset wins over stall and bubble
        ctl(0, 0, 0, 0);
        rand_id();
        step("pre_rst_stall");
        ctl(1, 0, 1, 1);
        step("rst_stall");

        // Saturation on the narrow counter
        ctl(0, 0, 1, 0);
        for (int i = 0; i < 20; i++) begin
            rand_id();
            step("bubble_sat");
        end
        check_eq("sat.bubble_15", 64'(s_bubble_cnt), 64'd15);
        check_eq("sat.wide_20", 64'(bubble_cnt), 64'd20);
        ctl(0, 0, 0, 1);
        for (int i = 0; i < 18; i++) begin
            rand_id();
            step("hold_sat");
        end
        check_eq("sat.hold_15", 64'(s_hold_cnt), 64'd15);

        // Random mix
        for (int i = 0; i < 300; i++) begin
            rand_id();
            ctl(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
            step("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
